// File: rtl/usb_rx_fifo.sv
// usb_rx_fifo: USB full-speed receive path (SYNC hunt, NRZI decode,
// bit unstuffing, EOP detect) feeding a small first-word-fall-through byte FIFO.
//
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   clk_en          one pulse per bit time from CDR; line sampled only then
//   d_i[1:0]        line state {dp,dm}: J=10, K=01, SE0=00, SE1=11
//   rx_data/rx_last FIFO head byte and its end-of-packet flag
//   rx_valid        FIFO non-empty; pops when rx_valid && rx_ready
//   rx_ready        consumer accepts head byte
//   active          high from SYNC completion until EOP end or abort exit
//   pkt_done        one-clk pulse on error-free EOP; rx_bytes updated with it
//   err/err_code    one-clk error pulse; cause held until next err
//                   (1 STUFF, 2 ALIGN, 3 OVERSIZE, 4 OVERFLOW, 5 SE1, 6 SYNC)
//   MAX_BYTES must fit the 11-bit byte counter (<= 2046).
module usb_rx_fifo #(
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_BITS   = 8,
  parameter int MAX_BYTES   = 1026,
  parameter int EOP_SE0_MIN = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic [1:0]  d_i,
  output logic [7:0]  rx_data,
  output logic        rx_last,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        active,
  output logic        pkt_done,
  output logic [10:0] rx_bytes,
  output logic        err,
  output logic [2:0]  err_code
);

  localparam logic [1:0] LS_SE0 = 2'b00;
  localparam logic [1:0] LS_K   = 2'b01;
  localparam logic [1:0] LS_J   = 2'b10;
  localparam logic [1:0] LS_SE1 = 2'b11;

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);

  localparam logic [4:0]  SYNC_LAST = 5'(SYNC_BITS - 1);
  localparam logic [4:0]  SYNC_ERR  = 5'd4;
  localparam logic [4:0]  SE0_MIN   = 5'(EOP_SE0_MIN);
  localparam logic [4:0]  CNT_SAT   = 5'd31;
  localparam logic [10:0] MAX_CNT   = 11'(MAX_BYTES);

  localparam logic [2:0] E_STUFF    = 3'd1;
  localparam logic [2:0] E_ALIGN    = 3'd2;
  localparam logic [2:0] E_OVERSIZE = 3'd3;
  localparam logic [2:0] E_OVERFLOW = 3'd4;
  localparam logic [2:0] E_SE1      = 3'd5;
  localparam logic [2:0] E_SYNC     = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_DATA,
    S_EOP,
    S_ABORT
  } state_t;

  state_t      state, state_d;
  logic [1:0]  prev, prev_d;
  logic [2:0]  ones, ones_d;
  logic [2:0]  bitc, bitc_d;
  logic [7:0]  shreg, shreg_d;
  logic [7:0]  held, held_d;
  logic        held_v, held_v_d;
  logic [10:0] bytes, bytes_d;
  logic [4:0]  cnt, cnt_d;
  logic        active_d;

  logic        se0, se1;
  logic        nrzi_bit;
  logic [7:0]  byte_new;
  logic [1:0]  sync_exp;

  logic        abort, sync_fail, go_active;
  logic        fire_err, fire_done;
  logic [2:0]  code;
  logic        push_req, push_last, push_ok;
  logic        pop, full;

  logic [8:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] rptr, wptr;
  logic [AW:0]   fcnt;

  assign se0      = (d_i == LS_SE0);
  assign se1      = (d_i == LS_SE1);
  assign nrzi_bit = (d_i == prev);
  assign byte_new = {nrzi_bit, shreg[7:1]};
  // Alternating K/J from K, except the final symbol which repeats K.
  assign sync_exp = (cnt == SYNC_LAST) ? LS_K :
                    (cnt[0] ? LS_J : LS_K);

  assign rx_valid = (fcnt != '0);
  assign full     = (fcnt == DEPTH);
  assign pop      = rx_valid && rx_ready;
  assign push_ok  = push_req && (!full || pop);
  assign rx_data  = mem[rptr][7:0];
  assign rx_last  = mem[rptr][8];
  assign fire_err = abort || sync_fail;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d   = state;
    prev_d    = prev;
    ones_d    = ones;
    bitc_d    = bitc;
    shreg_d   = shreg;
    held_d    = held;
    held_v_d  = held_v;
    bytes_d   = bytes;
    cnt_d     = cnt;
    abort     = 1'b0;
    sync_fail = 1'b0;
    go_active = 1'b0;
    fire_done = 1'b0;
    code      = 3'd0;
    push_req  = 1'b0;
    push_last = 1'b0;
    if (clk_en) begin
      unique case (state)
        S_IDLE: begin
          if (d_i == LS_K) begin
            state_d = S_SYNC;
            cnt_d   = 5'd1;
          end
        end
        S_SYNC: begin
          unique case (1'b1)
            se1: begin
              abort = 1'b1;
              code  = E_SE1;
            end
            (d_i == sync_exp): begin
              if (cnt == SYNC_LAST) begin
                state_d   = S_DATA;
                prev_d    = LS_K;
                ones_d    = 3'd0;
                bitc_d    = 3'd0;
                bytes_d   = 11'd0;
                held_v_d  = 1'b0;
                cnt_d     = 5'd0;
                go_active = 1'b1;
              end else begin
                cnt_d = cnt + 5'd1;
              end
            end
            default: begin
              // A near-complete SYNC that breaks is worth reporting;
              // a short false start is just line noise.
              state_d = S_IDLE;
              cnt_d   = 5'd0;
              if (cnt >= SYNC_ERR) begin
                sync_fail = 1'b1;
                code      = E_SYNC;
              end
            end
          endcase
        end
        S_DATA: begin
          unique case (1'b1)
            se1: begin
              abort = 1'b1;
              code  = E_SE1;
            end
            se0: begin
              if (bitc != 3'd0) begin
                abort = 1'b1;
                code  = E_ALIGN;
              end else begin
                state_d = S_EOP;
                cnt_d   = 5'd1;
              end
            end
            default: begin
              prev_d = d_i;
              if (ones == 3'd6) begin
                // Stuffed position: a 0 is dropped, a 1 is a violation.
                if (nrzi_bit) begin
                  abort = 1'b1;
                  code  = E_STUFF;
                end else begin
                  ones_d = 3'd0;
                end
              end else begin
                ones_d  = nrzi_bit ? ones + 3'd1 : 3'd0;
                shreg_d = byte_new;
                bitc_d  = bitc + 3'd1;
                if (bitc == 3'd7) begin
                  held_d   = byte_new;
                  held_v_d = 1'b1;
                  bytes_d  = bytes + 11'd1;
                  push_req = held_v;
                  if (held_v && full && !pop) begin
                    abort = 1'b1;
                    code  = E_OVERFLOW;
                  end else if (bytes == MAX_CNT) begin
                    abort = 1'b1;
                    code  = E_OVERSIZE;
                  end
                end
              end
            end
          endcase
        end
        S_EOP: begin
          unique case (1'b1)
            se1: begin
              abort = 1'b1;
              code  = E_SE1;
            end
            se0: begin
              if (cnt != CNT_SAT) cnt_d = cnt + 5'd1;
            end
            (d_i == LS_J && cnt >= SE0_MIN): begin
              push_req  = held_v;
              push_last = 1'b1;
              if (held_v && full && !pop) begin
                abort = 1'b1;
                code  = E_OVERFLOW;
              end else begin
                fire_done = 1'b1;
                state_d   = S_IDLE;
                held_v_d  = 1'b0;
                cnt_d     = 5'd0;
              end
            end
            default: begin
              abort = 1'b1;
              code  = E_ALIGN;
            end
          endcase
        end
        S_ABORT: begin
          if (d_i == LS_J) begin
            if (cnt != 5'd0) begin
              state_d = S_IDLE;
              cnt_d   = 5'd0;
            end else begin
              cnt_d = 5'd1;
            end
          end else begin
            cnt_d = 5'd0;
          end
        end
        default: state_d = S_IDLE;
      endcase
      if (abort) begin
        state_d  = S_ABORT;
        cnt_d    = 5'd0;
        held_v_d = 1'b0;
      end
    end
  end

  always_comb begin
    active_d = active;
    if (go_active)              active_d = 1'b1;
    else if (state_d == S_IDLE) active_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev     <= LS_J;
      ones     <= 3'd0;
      bitc     <= 3'd0;
      shreg    <= 8'd0;
      held     <= 8'd0;
      held_v   <= 1'b0;
      bytes    <= 11'd0;
      cnt      <= 5'd0;
      active   <= 1'b0;
      err      <= 1'b0;
      err_code <= 3'd0;
      pkt_done <= 1'b0;
      rx_bytes <= 11'd0;
    end else begin
      prev     <= prev_d;
      ones     <= ones_d;
      bitc     <= bitc_d;
      shreg    <= shreg_d;
      held     <= held_d;
      held_v   <= held_v_d;
      bytes    <= bytes_d;
      cnt      <= cnt_d;
      active   <= active_d;
      err      <= fire_err;
      pkt_done <= fire_done;
      if (fire_err)  err_code <= code;
      if (fire_done) rx_bytes <= bytes;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rptr <= '0;
      wptr <= '0;
      fcnt <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wptr] <= {push_last, held};
        wptr      <= wptr + AW'(1);
      end
      if (pop) rptr <= rptr + AW'(1);
      fcnt <= fcnt + {{AW{1'b0}}, push_ok}
                   - {{AW{1'b0}}, pop};
    end
  end

endmodule

// File: tb/tb_usb_rx_fifo.sv
// tb_usb_rx_fifo: packet-level bench for usb_rx_fifo; a line encoder drives
// symbols and a byte scoreboard plus event counters check the outputs.
module tb_usb_rx_fifo;

  localparam int DEPTH = 4;
  localparam int MAXB  = 16;
  localparam int SB    = 8;

  localparam logic [1:0] SE0 = 2'b00;
  localparam logic [1:0] K   = 2'b01;
  localparam logic [1:0] J   = 2'b10;
  localparam logic [1:0] SE1 = 2'b11;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clk_en = 1'b0;
  logic [1:0]  d_i = J;
  logic        rx_ready = 1'b1;
  logic [7:0]  rx_data;
  logic        rx_last;
  logic        rx_valid;
  logic        active;
  logic        pkt_done;
  logic [10:0] rx_bytes;
  logic        err;
  logic [2:0]  err_code;

  usb_rx_fifo #(
    .FIFO_DEPTH (DEPTH),
    .SYNC_BITS  (SB),
    .MAX_BYTES  (MAXB),
    .EOP_SE0_MIN(1)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .clk_en  (clk_en),
    .d_i     (d_i),
    .rx_data (rx_data),
    .rx_last (rx_last),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .active  (active),
    .pkt_done(pkt_done),
    .rx_bytes(rx_bytes),
    .err     (err),
    .err_code(err_code)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int err_cnt = 0;
  int done_cnt = 0;
  int err0 = 0;
  int done0 = 0;
  logic [2:0]  last_code = 3'd0;
  logic [10:0] last_bytes = 11'd0;
  logic [8:0]  expq[$];
  logic [7:0]  pkt[$];
  logic [1:0]  lvl = K;
  int          ones = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Consumer side: every accepted head byte is compared with the next
  // expected {last, byte}; pulses are counted for end-of-packet checks.
  always @(negedge clk) begin
    if (!reset) begin
      if (rx_valid && rx_ready) begin
        logic [31:0] e;
        e = (expq.size() != 0) ? {23'd0, expq.pop_front()} : 32'hFFFF_FFFF;
        check("pop", {23'd0, rx_last, rx_data}, e);
      end
      if (err) begin
        err_cnt++;
        last_code = err_code;
      end
      if (pkt_done) begin
        done_cnt++;
        last_bytes = rx_bytes;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sym(input logic [1:0] s);
    int gap;
    gap = $urandom_range(0, 1);
    d_i = s;
    repeat (gap) begin
      clk_en = 1'b0;
      tick();
    end
    clk_en = 1'b1;
    tick();
    clk_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) sym(J);
  endtask

  task automatic tx_sync();
    for (int i = 0; i < SB - 2; i++) sym((i % 2 != 0) ? J : K);
    sym(K);
    sym(K);
    lvl = K;
    ones = 0;
  endtask

  task automatic tx_bit(input logic b, input bit stuff);
    if (!b) lvl = (lvl == J) ? K : J;
    sym(lvl);
    ones = b ? ones + 1 : 0;
    if (stuff && ones == 6) begin
      lvl = (lvl == J) ? K : J;
      sym(lvl);
      ones = 0;
    end
  endtask

  task automatic tx_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) tx_bit(v[i], 1'b1);
  endtask

  task automatic tx_eop();
    sym(SE0);
    sym(SE0);
    sym(J);
  endtask

  task automatic begin_pkt();
    err0 = err_cnt;
    done0 = done_cnt;
  endtask

  task automatic expect_end(input string tag, input int n_err,
                            input logic [2:0] code, input int n_done,
                            input int nbytes);
    check({tag, "_done"}, 32'(done_cnt - done0), 32'(n_done));
    check({tag, "_err"}, 32'(err_cnt - err0), 32'(n_err));
    if (n_err != 0) begin
      check({tag, "_code"}, 32'(last_code), 32'(code));
      check({tag, "_code_held"}, 32'(err_code), 32'(code));
    end
    if (n_done != 0) check({tag, "_bytes"}, 32'(last_bytes), 32'(nbytes));
    check({tag, "_drained"}, 32'(expq.size()), 32'd0);
    check({tag, "_active"}, 32'(active), 32'd0);
  endtask

  // Error-free packet from pkt[]: every byte comes out, last on the final.
  task automatic good_pkt(input string tag);
    int n;
    n = pkt.size();
    for (int i = 0; i < n; i++) expq.push_back({(i == n - 1), pkt[i]});
    begin_pkt();
    tx_sync();
    check({tag, "_active_on"}, 32'(active), 32'd1);
    for (int i = 0; i < n; i++) tx_byte(pkt[i]);
    tx_eop();
    idle(3);
    expect_end(tag, 0, 3'd0, 1, n);
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) tick();
    check("rst_valid", 32'(rx_valid), 32'd0);
    check("rst_data", 32'(rx_data), 32'd0);
    check("rst_last", 32'(rx_last), 32'd0);
    check("rst_active", 32'(active), 32'd0);
    check("rst_done", 32'(pkt_done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_code", 32'(err_code), 32'd0);
    check("rst_bytes", 32'(rx_bytes), 32'd0);
    reset = 1'b0;
    idle(3);

    pkt = '{8'hC3, 8'h01, 8'h02};
    good_pkt("basic");

    pkt = '{8'hFF, 8'h00};
    good_pkt("stuff_ok");

    pkt = {};
    good_pkt("zero");

    for (int r = 0; r < 8; r++) begin
      int len;
      len = $urandom_range(0, 6);
      pkt = {};
      for (int i = 0; i < len; i++) pkt.push_back(8'($urandom));
      good_pkt("rand");
    end

    pkt = {};
    for (int i = 0; i < MAXB; i++) pkt.push_back(8'($urandom));
    good_pkt("max_len");

    // Seven ones with no stuffed zero after two good bytes.
    begin_pkt();
    expq.push_back({1'b0, 8'h12});
    tx_sync();
    tx_byte(8'h12);
    tx_byte(8'h34);
    for (int i = 0; i < 7; i++) tx_bit(1'b1, 1'b0);
    check("stuff_active_err", 32'(active), 32'd1);
    sym(J);
    check("stuff_active_j1", 32'(active), 32'd1);
    sym(J);
    check("stuff_active_j2", 32'(active), 32'd0);
    idle(2);
    expect_end("stuff", 1, 3'd1, 0, 0);

    // FIFO overflow with consumer stalled.
    rx_ready = 1'b0;
    begin_pkt();
    for (int i = 0; i < DEPTH; i++) expq.push_back({1'b0, 8'(8'h40 + i)});
    tx_sync();
    for (int i = 0; i < 7; i++) tx_byte(8'(8'h40 + i));
    tx_eop();
    idle(3);
    check("ovf_valid", 32'(rx_valid), 32'd1);
    check("ovf_head", 32'(rx_data), 32'h40);
    rx_ready = 1'b1;
    idle(6);
    expect_end("ovf", 1, 3'd4, 0, 0);

    // SE0 three bits into the second byte.
    begin_pkt();
    expq.push_back({1'b0, 8'h11});
    tx_sync();
    tx_byte(8'h11);
    tx_byte(8'h22);
    tx_bit(1'b1, 1'b1);
    tx_bit(1'b0, 1'b1);
    tx_bit(1'b1, 1'b1);
    tx_eop();
    idle(3);
    expect_end("align", 1, 3'd2, 0, 0);

    // K during EOP.
    begin_pkt();
    tx_sync();
    tx_byte(8'h55);
    sym(SE0);
    sym(K);
    idle(3);
    expect_end("eop_k", 1, 3'd2, 0, 0);

    // One byte beyond MAX_BYTES.
    begin_pkt();
    pkt = {};
    for (int i = 0; i <= MAXB; i++) pkt.push_back(8'($urandom));
    for (int i = 0; i < MAXB; i++) expq.push_back({1'b0, pkt[i]});
    tx_sync();
    for (int i = 0; i <= MAXB; i++) tx_byte(pkt[i]);
    tx_eop();
    idle(3);
    expect_end("oversize", 1, 3'd3, 0, 0);

    // SE1 in the middle of data.
    begin_pkt();
    tx_sync();
    tx_byte(8'hA5);
    tx_bit(1'b1, 1'b1);
    sym(SE1);
    idle(3);
    expect_end("se1", 1, 3'd5, 0, 0);

    // SYNC broken after five good symbols, then a short false start.
    begin_pkt();
    sym(K); sym(J); sym(K); sym(J); sym(K); sym(K);
    idle(2);
    expect_end("sync", 1, 3'd6, 0, 0);
    begin_pkt();
    sym(K); sym(J); sym(J);
    idle(2);
    expect_end("sync_short", 0, 3'd0, 0, 0);

    // Reset in the middle of a packet with bytes already queued.
    rx_ready = 1'b0;
    begin_pkt();
    tx_sync();
    tx_byte(8'h77);
    tx_byte(8'h88);
    tx_byte(8'h99);
    check("rst_mid_pre_valid", 32'(rx_valid), 32'd1);
    reset = 1'b1;
    tick();
    check("rst_mid_valid", 32'(rx_valid), 32'd0);
    check("rst_mid_active", 32'(active), 32'd0);
    reset = 1'b0;
    rx_ready = 1'b1;
    idle(3);
    expect_end("rst_mid", 0, 3'd0, 0, 0);

    pkt = '{8'h5A, 8'h7E, 8'hFE};
    good_pkt("after_rst");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
